mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
- Initiator side of the iterative multiplier start/annul/ready handshake, placed in the EX stage.
- Accepts multiply requests from the pipeline and latches the operands, holding them stable for the whole operation.
- Drives start/annul, stalls the pipeline until the multiplier's ready pulse, then captures the 64-bit product into the HI/LO registers.
- Also services MTHI/MTLO writes and provides HI/LO read data.

Parameters:
- TIMEOUT_CYCLES, 63: maximum cycles in WAIT without ready before forced abort.
- CNT_W, 6: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_i  in  1  multiply request valid (MULT/MULTU in EX)
- signed_i  in  1  1 = MULT, 0 = MULTU
- src_a_i  in  32  multiplicand
- src_b_i  in  32  multiplier
- flush_i  in  1  pipeline flush (exception or branch kill)
- hi_we_i  in  1  MTHI write enable
- lo_we_i  in  1  MTLO write enable
- wdata_i  in  32  MTHI/MTLO data
- mul_ready_i  in  1  ready from the multiplier
- mul_result_i  in  64  product from the multiplier
- mul_start_o  out  1  start to the multiplier
- mul_annul_o  out  1  annul to the multiplier
- mul_signed_o  out  1  signed select, held
- mul_op_a_o  out  32  operand A, held
- mul_op_b_o  out  32  operand B, held
- stall_o  out  1  pipeline stall (combinational)
- hi_o  out  32  HI register
- lo_o  out  32  LO register
- timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values: state=IDLE; every output register 0; hi_o=lo_o=0; watchdog count=0.
- States: IDLE, WAIT, DRAIN.
- IDLE:
  - req_i & !flush_i at an edge: latch signed/src_a/src_b into the op registers, clear the watchdog, go to WAIT, set mul_start_o=1.
  - req_i & flush_i: no action.
  - hi_we_i/lo_we_i write HI/LO from wdata_i; both may be set in the same cycle.
- WAIT:
  - mul_start_o=1; op registers frozen, because the multiplier samples operand signs again when it finishes.
  - The watchdog increments each cycle.
  - mul_ready_i=1: {hi,lo} <= mul_result_i (hi = [63:32]); mul_start_o <= 0; go to DRAIN.
  - flush_i=1: mul_annul_o=1 for exactly one cycle; mul_start_o <= 0; go to DRAIN; HI/LO unchanged.
  - Watchdog reaches TIMEOUT_CYCLES: same action as flush, plus timeout_o pulse.
  - flush_i and mul_ready_i in the same cycle: flush wins, no HI/LO write.
- DRAIN:
  - Exactly one cycle with start=0 and annul=0, so the multiplier returns to idle and drops ready.
  - Then go to IDLE.
  - A req_i arriving here is stalled and is accepted in IDLE.
- stall_o = (req_i & !flush_i & state != WAIT) | (state == WAIT & !mul_ready_i & !flush_i).
  - This includes the request cycle itself.
  - It deasserts in the cycle where ready is seen.
- Latency, counting E0 as the accepting edge:
  - The multiplier starts at E0+1 and asserts ready after E0+35.
  - HI/LO are updated at E0+36.
  - The stall lasts 36 cycles from request to ready-seen.
- hi_o/lo_o read the registers directly; there is no bypass of the in-flight product.
- MTHI/MTLO writes during WAIT or DRAIN are ignored; the stall guarantees none occur.
- Reset mid-operation: return to IDLE with all outputs 0. The multiplier shares rst and resets with it.

Decomposition:
- Shared package (mul_pkg):
  - state encoding constants (IDLE=2'b00, WAIT=2'b01, DRAIN=2'b10);
  - MUL_RES_W=64;
  - HILO_W=32.
- Sub-module hilo_reg: HI/LO storage with a 64-bit product write port and independent 32-bit MTHI/MTLO write ports. Product write takes priority.

Test Plan:
- MULTU 0xFFFFFFFF*0x00000002 with a behavioural multiplier model -> start high 35 cycles, stall 36 cycles, hi=0x00000001, lo=0xFFFFFFFE.
- MULT 0xFFFFFFFD(-3)*0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; op outputs constant throughout WAIT.
- Flush at cycle 10 of WAIT after hi preloaded 0x12345678 via MTHI -> annul one-cycle pulse, DRAIN, IDLE; hi stays 0x12345678; no timeout pulse.
- Back-to-back requests, second req_i held high -> second accepted one cycle after DRAIN (IDLE edge); stall continuous across both.
- Model never asserts ready, TIMEOUT_CYCLES=63 -> timeout_o pulse and annul after 63 WAIT cycles; HI/LO unchanged; return to IDLE.
- rst asserted mid-WAIT -> next cycle all outputs 0, state IDLE; flush_i coinciding with ready -> no HI/LO write.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and widths for the EX-stage multiplier issue logic.
// The state encoding is fixed so that it can be seen on debug taps.
package mul_pkg;
  localparam int MUL_RES_W = 64;
  localparam int HILO_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    DRAIN = 2'b10
  } mul_st_e;
endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Start/annul/ready handshake between the issue controller and the
// iterative multiplier. The operands are held for the whole operation.
interface mul_issue_ctrl_if;
  import mul_pkg::*;

  logic                 mul_start_o;
  logic                 mul_annul_o;
  logic                 mul_signed_o;
  logic [HILO_W-1:0]    mul_op_a_o;
  logic [HILO_W-1:0]    mul_op_b_o;
  logic                 mul_ready_i;
  logic [MUL_RES_W-1:0] mul_result_i;

  modport master (
    output mul_start_o,
    output mul_annul_o,
    output mul_signed_o,
    output mul_op_a_o,
    output mul_op_b_o,
    input  mul_ready_i,
    input  mul_result_i
  );

  modport slave (
    input  mul_start_o,
    input  mul_annul_o,
    input  mul_signed_o,
    input  mul_op_a_o,
    input  mul_op_b_o,
    output mul_ready_i,
    output mul_result_i
  );
endinterface

// File: rtl/hilo_reg.sv
// HI/LO architectural registers: 64-bit product port plus MTHI/MTLO.
// A product write overrides any MTHI/MTLO write in the same cycle.
module hilo_reg
  import mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prod_we_i,
  input  logic [MUL_RES_W-1:0] prod_i,
  input  logic                 hi_we_i,
  input  logic                 lo_we_i,
  input  logic [HILO_W-1:0]    wdata_i,
  output logic [HILO_W-1:0]    hi_o,
  output logic [HILO_W-1:0]    lo_o
);
  logic [HILO_W-1:0] r_hi;
  logic [HILO_W-1:0] r_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (prod_we_i) begin
      r_hi <= prod_i[MUL_RES_W-1:HILO_W];
      r_lo <= prod_i[HILO_W-1:0];
    end else begin
      if (hi_we_i) r_hi <= wdata_i;
      if (lo_we_i) r_lo <= wdata_i;
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;
endmodule

// File: rtl/mul_issue_ctrl.sv
// EX-stage initiator for the iterative multiplier: latches operands,
// stalls until ready, writes HI/LO, and aborts on flush or watchdog.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 63,
  parameter int CNT_W          = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              signed_i,
  input  logic [HILO_W-1:0] src_a_i,
  input  logic [HILO_W-1:0] src_b_i,
  input  logic              flush_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [HILO_W-1:0] wdata_i,
  mul_issue_ctrl_if.master  mul,
  output logic              stall_o,
  output logic [HILO_W-1:0] hi_o,
  output logic [HILO_W-1:0] lo_o,
  output logic              timeout_o
);
  mul_st_e           r_state;
  mul_st_e           w_next;
  logic [CNT_W-1:0]  r_wd;
  logic              r_start;
  logic              r_signed;
  logic [HILO_W-1:0] r_op_a;
  logic [HILO_W-1:0] r_op_b;
  logic              w_accept;
  logic              w_capture;
  logic              w_abort;
  logic              w_timeout;
  logic              w_wd_hit;
  logic              w_in_wait;
  logic              w_in_idle;

  assign w_in_wait = (r_state == WAIT);
  assign w_in_idle = (r_state == IDLE);
  assign w_wd_hit  = (r_wd == CNT_W'(TIMEOUT_CYCLES - 1));

  // flush beats ready; a late ready still beats the watchdog
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_i && !flush_i) begin
          w_next   = WAIT;
          w_accept = 1'b1;
        end
      end
      WAIT: begin
        if (flush_i) begin
          w_next  = DRAIN;
          w_abort = 1'b1;
        end else if (mul.mul_ready_i) begin
          w_next    = DRAIN;
          w_capture = 1'b1;
        end else if (w_wd_hit) begin
          w_next    = DRAIN;
          w_abort   = 1'b1;
          w_timeout = 1'b1;
        end
      end
      DRAIN:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wd     <= '0;
      r_start  <= 1'b0;
      r_signed <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_signed <= signed_i;
        r_op_a   <= src_a_i;
        r_op_b   <= src_b_i;
        r_wd     <= '0;
        r_start  <= 1'b1;
      end else if (w_in_wait) begin
        r_wd <= r_wd + CNT_W'(1);
        if (w_capture || w_abort) r_start <= 1'b0;
      end
    end
  end

  assign mul.mul_start_o  = r_start;
  assign mul.mul_annul_o  = w_abort;
  assign mul.mul_signed_o = r_signed;
  assign mul.mul_op_a_o   = r_op_a;
  assign mul.mul_op_b_o   = r_op_b;
  assign timeout_o        = w_timeout;

  assign stall_o = (req_i & ~flush_i & ~w_in_wait)
                 | (w_in_wait & ~mul.mul_ready_i & ~flush_i);

  hilo_reg u_hilo (
    .clk       (clk),
    .rst       (rst),
    .prod_we_i (w_capture),
    .prod_i    (mul.mul_result_i),
    .hi_we_i   (hi_we_i & w_in_idle),
    .lo_we_i   (lo_we_i & w_in_idle),
    .wdata_i   (wdata_i),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: behavioural multiplier plus a HI/LO
// scoreboard fed at request time and drained on each product capture.
module tb_mul_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        signed_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        flush_i;
  logic        hi_we_i;
  logic        lo_we_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        timeout_o;

  mul_issue_ctrl_if mif ();

  mul_issue_ctrl #(.TIMEOUT_CYCLES(63), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .signed_i  (signed_i),
    .src_a_i   (src_a_i),
    .src_b_i   (src_b_i),
    .flush_i   (flush_i),
    .hi_we_i   (hi_we_i),
    .lo_we_i   (lo_we_i),
    .wdata_i   (wdata_i),
    .mul       (mif),
    .stall_o   (stall_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // multiplier model: ready after 35 sampled start cycles
  int   m_cnt;
  logic m_rdy;
  bit   no_ready = 1'b0;
  bit   rdy_ovr  = 1'b0;
  logic [63:0] m_prod;

  always @(posedge clk) begin
    if (rst || !mif.mul_start_o || mif.mul_annul_o) begin
      m_cnt <= 0;
      m_rdy <= 1'b0;
    end else if (!m_rdy && !no_ready) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 34) m_rdy <= 1'b1;
    end
  end

  always_comb begin
    m_prod = '0;
    if (mif.mul_signed_o)
      m_prod = 64'(longint'($signed(mif.mul_op_a_o))
                 * longint'($signed(mif.mul_op_b_o)));
    else
      m_prod = {32'b0, mif.mul_op_a_o} * {32'b0, mif.mul_op_b_o};
  end

  assign mif.mul_ready_i  = m_rdy | rdy_ovr;
  assign mif.mul_result_i = m_prod;

  logic [63:0] sb[$];
  logic        cap_pend = 1'b0;

  always @(posedge clk)
    cap_pend <= !rst && mif.mul_start_o && mif.mul_ready_i && !flush_i;

  always @(negedge clk) begin
    if (cap_pend) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else chk("hilo", {hi_o, lo_o}, sb.pop_front());
    end
  end

  task automatic do_mul(input bit s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input bit keep, output int ncyc,
                        output int nst, output bit held);
    sb.push_back(exp);
    req_i = 1'b1; signed_i = s; src_a_i = a; src_b_i = b;
    ncyc = 0; nst = 0; held = 1'b1;
    #1;
    while (stall_o && ncyc < 200) begin
      ncyc++;
      if (mif.mul_start_o) begin
        if (!mif.mul_ready_i) nst++;
        if (mif.mul_op_a_o !== a || mif.mul_op_b_o !== b ||
            mif.mul_signed_o !== s) held = 1'b0;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (!keep) req_i = 1'b0;
  endtask

  task automatic start_op(input bit s, input logic [31:0] a,
                          input logic [31:0] b);
    req_i = 1'b1; signed_i = s; src_a_i = a; src_b_i = b;
    @(negedge clk);
    req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int  nc, ns, nc2, ns2, n;
    bit  hd, hd2;
    logic [31:0] ra, rb;

    rst = 1'b1; req_i = 0; signed_i = 0; src_a_i = 0; src_b_i = 0;
    flush_i = 0; hi_we_i = 0; lo_we_i = 0; wdata_i = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_start", mif.mul_start_o, 0);
    chk("rst_annul", mif.mul_annul_o, 0);
    chk("rst_ops", {mif.mul_signed_o, mif.mul_op_a_o, mif.mul_op_b_o}, 0);
    chk("rst_hilo", {hi_o, lo_o}, 0);
    chk("rst_stall_to", {stall_o, timeout_o}, 0);
    rst = 1'b0;

    @(negedge clk);
    hi_we_i = 1; lo_we_i = 1; wdata_i = 32'hA5A5_0001;
    @(negedge clk);
    hi_we_i = 0; lo_we_i = 0;
    #1 chk("mt_both", {hi_o, lo_o}, 64'hA5A5_0001_A5A5_0001);

    @(negedge clk);
    do_mul(0, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, 0, nc, ns, hd);
    chk("t1_stall_cyc", nc, 36);
    chk("t1_start_cyc", ns, 35);
    chk("t1_ops_held", hd, 1);

    @(negedge clk);
    do_mul(1, 32'hFFFF_FFFD, 32'h7, 64'hFFFF_FFFF_FFFF_FFEB, 0, nc, ns, hd);
    chk("t2_stall_cyc", nc, 36);
    chk("t2_ops_held", hd, 1);

    @(negedge clk);
    do_mul(1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000,
           1, nc, ns, hd);
    do_mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001,
           0, nc2, ns2, hd2);
    chk("b2b_first_stall", nc, 36);
    chk("b2b_second_stall", nc2, 37);
    chk("b2b_second_start", ns2, 35);
    chk("b2b_held", {hd, hd2}, 2'b11);

    @(negedge clk);
    hi_we_i = 1; wdata_i = 32'h1234_5678;
    @(negedge clk);
    hi_we_i = 0; lo_we_i = 1; wdata_i = 32'h9ABC_DEF0;
    @(negedge clk);
    lo_we_i = 0;
    #1 chk("mt_preload", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);
    @(negedge clk);
    start_op(0, 32'h3, 32'h5);
    repeat (9) @(negedge clk);
    #1 chk("fl_pre_annul", {mif.mul_start_o, mif.mul_annul_o}, 2'b10);
    flush_i = 1;
    #1;
    chk("fl_annul", mif.mul_annul_o, 1);
    chk("fl_stall_to", {stall_o, timeout_o}, 0);
    @(negedge clk);
    flush_i = 0;
    #1 chk("fl_drain", {mif.mul_start_o, mif.mul_annul_o, timeout_o}, 0);
    @(negedge clk);
    #1 chk("fl_hilo_kept", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);

    no_ready = 1;
    @(negedge clk);
    start_op(1, 32'h11, 32'h22);
    n = 1;
    while (!timeout_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycle", n, 63);
    chk("to_annul", mif.mul_annul_o, 1);
    @(negedge clk);
    #1 chk("to_pulse_end", {timeout_o, mif.mul_annul_o, mif.mul_start_o}, 0);
    @(negedge clk);
    #1 chk("to_hilo_kept", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);
    chk("to_idle_stall", stall_o, 0);

    @(negedge clk);
    start_op(0, 32'h7, 32'h9);
    repeat (3) @(negedge clk);
    flush_i = 1; rdy_ovr = 1;
    #1 chk("flrdy_stall_annul", {stall_o, mif.mul_annul_o}, 2'b01);
    @(negedge clk);
    flush_i = 0; rdy_ovr = 0;
    @(negedge clk);
    #1 chk("flrdy_hilo_kept", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);
    no_ready = 0;

    @(negedge clk);
    start_op(1, 32'h1234, 32'h5678);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    chk("mrst_hs", {mif.mul_start_o, mif.mul_annul_o, timeout_o}, 0);
    chk("mrst_ops", {mif.mul_signed_o, mif.mul_op_a_o, mif.mul_op_b_o}, 0);
    chk("mrst_hilo", {hi_o, lo_o}, 0);
    chk("mrst_stall", stall_o, 0);
    rst = 0;

    ra = $urandom; rb = $urandom;
    @(negedge clk);
    do_mul(0, ra, rb, {32'b0, ra} * {32'b0, rb}, 0, nc, ns, hd);
    chk("rnd_stall_cyc", nc, 36);

    repeat (3) @(negedge clk);
    chk("sb_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
